// File: rtl/mem_pkg.sv
// mem_pkg: shared types and default sizes for the MEM-stage store buffer
package mem_pkg;
    localparam int MEM_AW   = 32;
    localparam int MEM_DW   = 32;
    localparam int SB_DEPTH = 4;

    typedef logic [MEM_AW-3:0] waddr_t;

    typedef struct packed {
        logic              valid;
        waddr_t            waddr;
        logic [MEM_DW-1:0] data;
    } entry_t;
endpackage

// File: rtl/sb_match.sv
// sb_match: parallel word-address compare against every valid buffer entry
module sb_match
    import mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  entry_t                     ents [DEPTH],
    input  waddr_t                     waddr,
    output logic                       hit,
    output logic [DEPTH-1:0]           onehot,
    output logic [$clog2(DEPTH)-1:0]   idx
);
    localparam int PW = $clog2(DEPTH);

    // Coalescing keeps matches unique, so OR-encoding the one-hot vector is exact
    always_comb begin
        onehot = '0;
        idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            onehot[i] = ents[i].valid && (ents[i].waddr == waddr);
            idx       = onehot[i] ? (idx | PW'(i)) : idx;
        end
        hit = |onehot;
    end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: write-combining store FIFO that forwards to loads and drains on idle memory cycles
module store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = MEM_AW,
    parameter int DW    = MEM_DW
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          StoreReq,
    input  logic          LoadReq,
    input  logic [AW-1:0] Addr,
    input  logic [DW-1:0] WData,
    output logic [DW-1:0] LoadData,
    output logic          Stall,
    output logic          Empty,
    output logic          MemWE,
    output logic [AW-1:0] MemA,
    output logic [DW-1:0] MemWD,
    input  logic [DW-1:0] MemRD
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t          ents [DEPTH];
    logic [PW-1:0]   head, tail, idx;
    logic [CW-1:0]   count;
    logic [DEPTH-1:0] onehot;
    logic            hit, full, store_ok, acc_hit, acc_new, drain;
    waddr_t          waddr;
    logic            addr_lo_unused;

    assign waddr          = Addr[AW-1:2];
    assign addr_lo_unused = ^Addr[1:0];

    sb_match #(.DEPTH(DEPTH)) u_match (
        .ents   (ents),
        .waddr  (waddr),
        .hit    (hit),
        .onehot (onehot),
        .idx    (idx)
    );

    // Arbitration: a load owns the port; an accepted store keeps it busy; otherwise drain the head
    always_comb begin
        full     = count == CW'(DEPTH);
        Empty    = count == '0;
        store_ok = StoreReq && !LoadReq;
        Stall    = store_ok && !hit && full;
        acc_hit  = store_ok && hit;
        acc_new  = store_ok && !hit && !full;
        drain    = !LoadReq && !acc_hit && !acc_new && !Empty;
        MemWE    = drain;
        MemA     = drain ? {ents[head].waddr, 2'b00} : Addr;
        MemWD    = drain ? ents[head].data : '0;
        LoadData = hit ? ents[idx].data : MemRD;
    end

    // FIFO state: coalesce on hit, append on miss, retire the head when it drains
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) ents[i] <= '0;
        end else begin
            if (acc_hit) ents[idx].data <= WData;
            if (acc_new) begin
                ents[tail] <= '{valid: 1'b1, waddr: waddr, data: WData};
                tail       <= tail + PW'(1);
                count      <= count + CW'(1);
            end
            if (drain) begin
                ents[head].valid <= 1'b0;
                head             <= head + PW'(1);
                count            <= count - CW'(1);
            end
        end
    end
endmodule
